// File: rtl/simple_fpga_cvs_pkg.sv
// Shared constants and types for the simple_fpga_cvs I/O conditioning path.
package simple_fpga_cvs_pkg;

   localparam int IO_WIDTH = 5;

   typedef logic [IO_WIDTH-1:0] io_bus_t;

   // Roughly 1024 samples of the MMCM clock rejects typical switch bounce.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1024;
   localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage : simple_fpga_cvs_pkg

// File: rtl/in_debounce_if.sv
// Bundle of the raw input bus and its conditioned outputs.
// The master side drives the raw bits; the slave side is the conditioner.
interface in_debounce_if
   import simple_fpga_cvs_pkg::*;
#(
   parameter int WIDTH = IO_WIDTH
);

   logic [WIDTH-1:0] in_async;
   logic [WIDTH-1:0] out_stable;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] busy;

   modport master (
      output in_async,
      input  out_stable,
      input  rise,
      input  fall,
      input  busy
   );

   modport slave (
      input  in_async,
      output out_stable,
      output rise,
      output fall,
      output busy
   );

endinterface : in_debounce_if

// File: rtl/in_debounce_bit.sv
// Single-bit conditioner: synchronizer chain, mismatch counter that accepts a
// new level only after DEBOUNCE_CYCLES consecutive differing samples, and
// one-cycle rise/fall pulses coincident with the accepted level change.
module debounce_bit
   import simple_fpga_cvs_pkg::*;
#(
   parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic RESET_VALUE     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_async_i,
   output logic out_stable_o,
   output logic rise_o,
   output logic fall_o,
   output logic busy_o
);

   // The counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

   logic             syncBit;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   assign syncBit = sync_q[SYNC_STAGES-1];

   // Plain shift chain with nothing between flops, so metastability resolves.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_VALUE}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_async_i};
      end
   end

   // Count consecutive mismatches; on the last one adopt the new level and pulse.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (syncBit != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = syncBit;
            rise_d   = syncBit;
            fall_d   = ~syncBit;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Register debounce state and pulses; reset discards any pending count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         stable_q <= RESET_VALUE;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign out_stable_o = stable_q;
   assign rise_o       = rise_q;
   assign fall_o       = fall_q;
   assign busy_o       = (cnt_q != '0);

endmodule : debounce_bit

// File: rtl/in_debounce.sv
// Conditions the asynchronous input bus into a clean registered bus with
// per-bit debounce and edge pulses. Every bit is handled independently.
module in_debounce
   import simple_fpga_cvs_pkg::*;
#(
   parameter int               WIDTH           = IO_WIDTH,
   parameter int               SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic          clk,
   input  logic          rst,
   in_debounce_if.slave  bus
);

   for (genvar i = 0; i < WIDTH; i++) begin : gBit
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VALUE     (RESET_VALUE[i])
      ) uBit (
         .clk          (clk),
         .rst          (rst),
         .in_async_i   (bus.in_async[i]),
         .out_stable_o (bus.out_stable[i]),
         .rise_o       (bus.rise[i]),
         .fall_o       (bus.fall[i]),
         .busy_o       (bus.busy[i])
      );
   end

endmodule : in_debounce

// File: tb/tb_in_debounce.sv
// Directed bench for in_debounce: a DEBOUNCE_CYCLES=4 instance (latency 6)
// and a DEBOUNCE_CYCLES=1 instance (latency 3), sharing clock and reset.
module tb_in_debounce;
   import simple_fpga_cvs_pkg::*;

   logic clk;
   logic rst;
   int   errCount;
   int   checkCount;

   in_debounce_if #(.WIDTH(5)) busA ();
   in_debounce_if #(.WIDTH(5)) busB ();

   in_debounce #(
      .WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(5'h00)
   ) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA.slave)
   );

   in_debounce #(
      .WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VALUE(5'h00)
   ) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB.slave)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b);
      busA.in_async = a;
      busB.in_async = b;
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [4:0] observed,
                              input logic [4:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Run n edges with A's input fixed; a single accepted change lands on edge 6.
   task automatic settleA(input string tag, input logic [4:0] oldOut,
                          input logic [4:0] newOut, input int n);
      for (int k = 1; k <= n; k++) begin
         tick();
         checkOutput({tag, "_out"}, busA.out_stable, (k >= 6) ? newOut : oldOut);
         checkOutput({tag, "_rise"}, busA.rise, (k == 6) ? (newOut & ~oldOut) : 5'h00);
         checkOutput({tag, "_fall"}, busA.fall, (k == 6) ? (oldOut & ~newOut) : 5'h00);
      end
   endtask

   initial begin
      logic bounceLevel [4];
      errCount   = 0;
      checkCount = 0;
      bounceLevel = '{1'b1, 1'b0, 1'b1, 1'b0};

      // Reset held 3 cycles with all inputs high
      rst = 1'b1;
      applyStimulus(5'h1F, 5'h00);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("rst_out", busA.out_stable, 5'h00);
         checkOutput("rst_rise", busA.rise, 5'h00);
         checkOutput("rst_fall", busA.fall, 5'h00);
         checkOutput("rst_busy", busA.busy, 5'h00);
      end
      rst = 1'b0;
      settleA("rel", 5'h00, 5'h1F, 8);

      // Drop bit0 as a baseline for the glitch
      applyStimulus(5'h1E, 5'h00);
      settleA("drop0", 5'h1F, 5'h1E, 8);

      // Bit0 glitch lasting 3 samples: busy for 3 cycles, no output change
      applyStimulus(5'h1F, 5'h00);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 3) applyStimulus(5'h1E, 5'h00);
         checkOutput("glitch_busy", busA.busy, (k >= 3 && k <= 5) ? 5'h01 : 5'h00);
         checkOutput("glitch_out", busA.out_stable, 5'h1E);
         checkOutput("glitch_rise", busA.rise, 5'h00);
      end

      // Bring bit2 low before bouncing it
      applyStimulus(5'h1A, 5'h00);
      settleA("drop2", 5'h1E, 5'h1A, 8);

      // Bit2 bounces 1,0,1,0 two cycles each, then settles high
      for (int s = 0; s < 4; s++) begin
         applyStimulus({2'b11, bounceLevel[s], 2'b10}, 5'h00);
         for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("bounce_rise", busA.rise, 5'h00);
            checkOutput("bounce_fall", busA.fall, 5'h00);
         end
      end
      applyStimulus(5'h1E, 5'h00);
      settleA("bounce_end", 5'h1A, 5'h1E, 8);

      // Reach out_stable = 10000, then flip bit1 up and bit4 down together
      applyStimulus(5'h10, 5'h00);
      settleA("pre_sim", 5'h1E, 5'h10, 8);
      applyStimulus(5'h02, 5'h00);
      settleA("sim", 5'h10, 5'h02, 8);

      // Bit3 pending with counter=2, then a one-cycle reset
      applyStimulus(5'h0A, 5'h00);
      for (int k = 1; k <= 4; k++) tick();
      checkOutput("mid_busy", busA.busy, 5'h08);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_out", busA.out_stable, 5'h00);
      checkOutput("mid_rst_busy", busA.busy, 5'h00);
      checkOutput("mid_rst_rise", busA.rise, 5'h00);
      settleA("mid_rel", 5'h00, 5'h0A, 8);

      // DEBOUNCE_CYCLES=1: one-cycle pulse on bit0 passes with latency 3
      applyStimulus(5'h0A, 5'h01);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) applyStimulus(5'h0A, 5'h00);
         checkOutput("d1_out", busB.out_stable, (k == 3) ? 5'h01 : 5'h00);
         checkOutput("d1_rise", busB.rise, (k == 3) ? 5'h01 : 5'h00);
         checkOutput("d1_fall", busB.fall, (k == 4) ? 5'h01 : 5'h00);
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule : tb_in_debounce
